// File: rtl/uart_tx_port_if.sv
// -----------------------------------------------------------------------------
// uart_tx_port_if
// CPU-side peripheral bus bundle for the memory-mapped UART transmitter.
// It carries the common en/we/addr/din/dout peripheral contract.
//
// Signals:
//   en_i    peripheral select from the top-level address decoder
//   we_i    write enable (cpu_we)
//   addr_i  CPU address [11:0]; the peripheral decodes only [1:0]
//   din_i   CPU write data
//   dout_o  registered read data; valid one cycle after the read edge
//
// Modports:
//   master  the CPU / decoder side
//   slave   the peripheral side
// -----------------------------------------------------------------------------
interface uart_tx_port_if;
    logic        en_i;
    logic        we_i;
    logic [11:0] addr_i;
    logic [7:0]  din_i;
    logic [7:0]  dout_o;

    modport master (
        output en_i,
        output we_i,
        output addr_i,
        output din_i,
        input  dout_o
    );

    modport slave (
        input  en_i,
        input  we_i,
        input  addr_i,
        input  din_i,
        output dout_o
    );
endinterface

// File: rtl/uart_tx_port.sv
// -----------------------------------------------------------------------------
// uart_tx_port
// Memory-mapped UART transmitter. The CPU pushes bytes into a TX FIFO, and a
// baud-timed FSM sends each byte as an 8N1 frame on tx_o.
//
// Register map (addr_i[1:0]):
//   0 DATA    write pushes a byte; read returns 8'h00
//   1 STATUS  read: {4'b0, overflow, fsm_active, empty, full}; clears overflow
//   2 DIV_LO  divisor[7:0]
//   3 DIV_HI  divisor[15:8]
//
// Ports:
//   clk_i    CPU clock
//   rst_n_i  asynchronous active-low reset
//   bus_if   peripheral bus (slave modport), registered read data
//   tx_o     serial output, idles high
//   busy_o   registered: FIFO non-empty or a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx_port #(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter logic [15:0] DIVISOR_RESET = 16'd61
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    uart_tx_port_if.slave  bus_if,
    output logic           tx_o,
    output logic           busy_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overflow;
    logic [15:0] r_divisor;
    logic [7:0]  r_dout;

    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic [15:0] r_baud_cnt;
    logic [15:0] r_bit_len;
    logic        r_tx;
    logic        r_busy;

    logic [1:0]  w_reg;
    logic        w_wr;
    logic        w_rd;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_drop;
    logic        w_stat_rd;
    logic        w_pop;
    logic        w_bit_end;
    logic        w_tx;
    logic        w_busy;
    logic [7:0]  w_rd_data;
    logic        w_unused_addr;

    assign w_reg         = bus_if.addr_i[1:0];
    assign w_unused_addr = ^bus_if.addr_i[11:2];
    assign w_wr          = bus_if.en_i && bus_if.we_i;
    assign w_rd          = bus_if.en_i && !bus_if.we_i;

    // ---------------------------------------------------------------- FIFO
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Fullness is judged before the edge; a pop on the same edge frees no slot.
    assign w_push    = w_wr && (w_reg == 2'd0) && !w_full;
    assign w_drop    = w_wr && (w_reg == 2'd0) && w_full;
    assign w_stat_rd = w_rd && (w_reg == 2'd1);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus_if.din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_comb begin
        w_rd_data = 8'h00;
        unique case (w_reg)
            2'd0:    w_rd_data = 8'h00;
            2'd1:    w_rd_data = {4'h0, r_overflow, (r_state != StIdle), w_empty, w_full};
            2'd2:    w_rd_data = r_divisor[7:0];
            2'd3:    w_rd_data = r_divisor[15:8];
            default: w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dout     <= 8'h00;
            r_overflow <= 1'b0;
            r_divisor  <= DIVISOR_RESET;
        end else begin
            if (w_rd) begin
                r_dout <= w_rd_data;
            end
            // A drop on the same edge as a STATUS read keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_stat_rd) begin
                r_overflow <= 1'b0;
            end
            if (w_wr && (w_reg == 2'd2)) begin
                r_divisor[7:0] <= bus_if.din_i;
            end
            if (w_wr && (w_reg == 2'd3)) begin
                r_divisor[15:8] <= bus_if.din_i;
            end
        end
    end

    assign bus_if.dout_o = r_dout;

    // ------------------------------------------------------------- TX FSM
    assign w_bit_end = (r_baud_cnt == r_bit_len - 16'd1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_state_next = StData;
                end
            end
            StData: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_next = StStop;
                end
            end
            StStop: begin
                // Chain straight into the next start bit so queued frames leave no gap.
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = StStart;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        unique case (r_state)
            StStart: w_tx = 1'b0;
            StData:  w_tx = r_shift[0];
            default: w_tx = 1'b1;
        endcase
    end

    assign w_busy = !w_empty || (r_state != StIdle);

    // Frame datapath: bit length is latched at pop so divisor writes hit the next frame.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_shift    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_baud_cnt <= 16'd0;
            r_bit_len  <= 16'd1;
        end else if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr[AW-1:0]];
            r_bit_idx  <= 3'd0;
            r_baud_cnt <= 16'd0;
            r_bit_len  <= (r_divisor == 16'd0) ? 16'd1 : r_divisor;
        end else if (r_state != StIdle) begin
            if (w_bit_end) begin
                r_baud_cnt <= 16'd0;
                if (r_state == StData) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx;
            r_busy <= w_busy;
        end
    end

    assign tx_o   = r_tx;
    assign busy_o = r_busy;
endmodule

// File: tb/tb_uart_tx_port.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_port
// Directed bench for uart_tx_port. Bus inputs change on the falling edge, so
// the rising edge that follows a bus task is the transaction edge T; outputs
// are sampled on the next falling edge. A recorder logs tx_o 1 time unit after
// every rising edge while enabled: sample j is tx_o just after edge W0+j,
// where W0 is the edge of the first write issued after enabling it.
// -----------------------------------------------------------------------------
module tb_uart_tx_port;
    logic clk = 1'b0;
    logic rst_n;
    logic tx;
    logic busy;

    always #5 clk = ~clk;

    uart_tx_port_if bus ();

    uart_tx_port #(
        .FIFO_DEPTH    (16),
        .DIVISOR_RESET (16'd61)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_if  (bus),
        .tx_o    (tx),
        .busy_o  (busy)
    );

    int   n_total = 0;
    int   n_bad   = 0;
    logic rec     = 1'b0;
    logic q [$];

    always @(posedge clk) begin
        #1;
        if (rec) q.push_back(tx);
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.en_i   = 1'b1;
        bus.we_i   = 1'b1;
        bus.addr_i = {10'h2C0, a};
        bus.din_i  = d;
        @(negedge clk);
        bus.en_i   = 1'b0;
        bus.we_i   = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus.en_i   = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = {10'h2C0, a};
        @(negedge clk);
        d          = bus.dout_o;
        bus.en_i   = 1'b0;
    endtask

    task automatic wait_rec(input int m);
        for (int i = 0; i < 2000 && q.size() < m; i++) @(negedge clk);
        check("rec_len", 16'(q.size() >= m), 16'd1);
    endtask

    function automatic logic [9:0] frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    initial begin
        logic [7:0] rd;
        logic [9:0] fr;
        logic [9:0] obs;
        logic [9:0] obs2;
        int         cnt;

        rst_n      = 1'b0;
        bus.en_i   = 1'b0;
        bus.we_i   = 1'b0;
        bus.addr_i = 12'h000;
        bus.din_i  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_dout", {8'h00, bus.dout_o}, 16'h0000);
        check("rst_tx", {15'd0, tx}, 16'd1);
        check("rst_busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset register values.
        bus_read(2'd1, rd); check("status_rst", {8'h00, rd}, 16'h0002);
        bus_read(2'd2, rd); check("div_lo_rst", {8'h00, rd}, 16'h003D);
        bus_read(2'd0, rd); check("data_rd", {8'h00, rd}, 16'h0000);
        bus_read(2'd3, rd); check("div_hi_rst", {8'h00, rd}, 16'h0000);
        check("idle_tx", {15'd0, tx}, 16'd1);

        // Single 0xA5 frame, 4 clocks per bit.
        bus_write(2'd2, 8'd4);
        bus_write(2'd3, 8'd0);
        bus_write(2'd0, 8'hA5);
        check("a5_busy_t", {15'd0, busy}, 16'd0);
        check("a5_tx_t", {15'd0, tx}, 16'd1);
        @(negedge clk);
        check("a5_busy_t1", {15'd0, busy}, 16'd1);
        check("a5_tx_t1", {15'd0, tx}, 16'd1);
        fr = frame(8'hA5);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("a5_tx", {15'd0, tx}, {15'd0, fr[k/4]});
        end
        check("a5_busy_last", {15'd0, busy}, 16'd1);
        @(negedge clk);
        check("a5_busy_end", {15'd0, busy}, 16'd0);
        check("a5_tx_end", {15'd0, tx}, 16'd1);

        // Burst at divisor 1. The FSM pops one byte at W1 and another at W11,
        // so the FIFO first overflows on the 19th consecutive write.
        bus_write(2'd2, 8'd1);
        q.delete();
        rec = 1'b1;
        for (int i = 0; i < 19; i++) bus_write(2'd0, 8'h30 + 8'(i));
        bus_read(2'd1, rd); check("ovf_status1", {8'h00, rd}, 16'h000D);
        bus_read(2'd1, rd); check("ovf_status2", {8'h00, rd}, 16'h0005);
        wait_rec(196);
        check("burst_pre0", {15'd0, q[0]}, 16'd1);
        check("burst_pre1", {15'd0, q[1]}, 16'd1);
        for (int f = 0; f < 18; f++) begin
            for (int b = 0; b < 10; b++) obs[b] = q[2 + 10 * f + b];
            check("burst_frame", {6'd0, obs}, {6'd0, frame(8'h30 + 8'(f))});
        end
        cnt = 0;
        for (int j = 182; j < 196; j++) if (q[j] !== 1'b1) cnt++;
        check("burst_tail_lows", 16'(cnt), 16'd0);
        rec = 1'b0;
        bus_read(2'd1, rd); check("burst_status_end", {8'h00, rd}, 16'h0002);
        check("burst_busy_end", {15'd0, busy}, 16'd0);

        // Divisor rewritten mid-frame: 0x5A keeps 4-clock bits, 0xC3 uses 8.
        bus_write(2'd2, 8'd4);
        q.delete();
        rec = 1'b1;
        bus_write(2'd0, 8'h5A);
        bus_write(2'd0, 8'hC3);
        bus_write(2'd2, 8'd8);
        wait_rec(125);
        for (int b = 0; b < 10; b++) begin
            obs[b]  = q[2 + 4 * b];
            obs2[b] = q[5 + 4 * b];
        end
        check("div4_first", {6'd0, obs}, {6'd0, frame(8'h5A)});
        check("div4_last", {6'd0, obs2}, {6'd0, frame(8'h5A)});
        for (int b = 0; b < 10; b++) begin
            obs[b]  = q[42 + 8 * b];
            obs2[b] = q[49 + 8 * b];
        end
        check("div8_first", {6'd0, obs}, {6'd0, frame(8'hC3)});
        check("div8_last", {6'd0, obs2}, {6'd0, frame(8'hC3)});
        check("div8_after", {15'd0, q[122]}, 16'd1);
        rec = 1'b0;

        // Reset during data bit 0 of a zero byte, with a second byte queued.
        bus_write(2'd0, 8'h00);
        bus_write(2'd0, 8'h00);
        repeat (11) @(negedge clk);
        check("mid_tx_low", {15'd0, tx}, 16'd0);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", {15'd0, tx}, 16'd1);
        check("rst_async_busy", {15'd0, busy}, 16'd0);
        check("rst_async_dout", {8'h00, bus.dout_o}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(2'd1, rd); check("post_rst_status", {8'h00, rd}, 16'h0002);
        bus_read(2'd2, rd); check("post_rst_div", {8'h00, rd}, 16'h003D);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) cnt++;
        end
        check("post_rst_lows", 16'(cnt), 16'd0);
        check("post_rst_busy", {15'd0, busy}, 16'd0);

        // Divisor 0 behaves as 1: nine low clocks, then the stop bit.
        bus_write(2'd2, 8'd0);
        q.delete();
        rec = 1'b1;
        bus_write(2'd0, 8'h00);
        wait_rec(16);
        check("div0_pre", {15'd0, q[1]}, 16'd1);
        cnt = 0;
        for (int j = 2; j < 11; j++) if (q[j] !== 1'b0) cnt++;
        check("div0_low_highs", 16'(cnt), 16'd0);
        check("div0_stop", {15'd0, q[11]}, 16'd1);
        check("div0_idle", {15'd0, q[12]}, 16'd1);
        rec = 1'b0;
        bus_read(2'd1, rd); check("div0_status", {8'h00, rd}, 16'h0002);
        check("div0_busy", {15'd0, busy}, 16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
